// File: rtl/calc_arith_pkg.sv
// Shared arithmetic definitions for the calculator datapath.
// Holds the default operand widths and the start/run/finish FSM state type.
package calc_arith_pkg;

  localparam int CALC_DW = 16;
  localparam int CALC_VW = 8;
  localparam int CALC_QW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/repeated_div_step.sv
// One iteration of the repeated-subtraction divider: compare, then subtract only when it fits.
// Purely combinational; rem_next equals rem when div does not fit, so it never underflows.
module repeated_div_step
  import calc_arith_pkg::*;
#(
  parameter int W = CALC_DW
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] div,
  output logic         ge,
  output logic [W-1:0] rem_next
);

  always_comb begin
    ge       = (rem >= div);
    rem_next = rem;
    if (ge) begin
      rem_next = rem - div;
    end
  end

endmodule

// File: rtl/repeated_div_16by8.sv
// Multi-cycle unsigned divider by repeated subtraction with start/done control; latency quotient+2.
// Build option REPEATED_DIV_OVF_EN: stop at an all-ones quotient and flag ovf (else quotient wraps).
module repeated_div_16by8
  import calc_arith_pkg::*;
#(
  parameter int DW = CALC_DW,
  parameter int VW = CALC_VW,
  parameter int QW = CALC_QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic          ovf
);

  state_t        state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] div_q, div_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [QW-1:0] quotient_q, quotient_d;
  logic [DW-1:0] remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div_zero_q, div_zero_d;

  logic          ge;
  logic [DW-1:0] rem_next;

`ifdef REPEATED_DIV_OVF_EN
  logic          ovf_q, ovf_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          quo_max;

  assign quo_max = &quo_q;
`endif

  repeated_div_step #(
    .W(DW)
  ) u_step (
    .rem      (rem_q),
    .div      (div_q),
    .ge       (ge),
    .rem_next (rem_next)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
    div_zero_d  = div_zero_q;
`ifdef REPEATED_DIV_OVF_EN
    ovf_d       = ovf_q;
    ovf_pend_d  = ovf_pend_q;
`endif

    // A new request wins in every state and silently abandons any running operation.
    if (start) begin
      rem_d      = dividend;
      div_d      = DW'(divisor);
      quo_d      = '0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
`ifdef REPEATED_DIV_OVF_EN
      ovf_d      = 1'b0;
      ovf_pend_d = 1'b0;
`endif
      state_d    = (divisor == '0) ? ST_FIN : ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_RUN: begin
`ifdef REPEATED_DIV_OVF_EN
          if (ge && quo_max) begin
            ovf_pend_d = 1'b1;
            state_d    = ST_FIN;
          end else
`endif
          if (ge) begin
            rem_d = rem_next;
            quo_d = quo_q + 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end

        ST_FIN: begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = quo_q;
          remainder_d = rem_q;
          // Only a zero divisor can reach FIN with div_q still zero; rem_q then holds the dividend.
          if (div_q == '0) begin
            quotient_d = '1;
            div_zero_d = 1'b1;
          end
`ifdef REPEATED_DIV_OVF_EN
          else if (ovf_pend_q) begin
            quotient_d = '1;
            ovf_d      = 1'b1;
          end
`endif
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
`ifdef REPEATED_DIV_OVF_EN
      ovf_q       <= 1'b0;
      ovf_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
`ifdef REPEATED_DIV_OVF_EN
      ovf_q       <= ovf_d;
      ovf_pend_q  <= ovf_pend_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
`ifdef REPEATED_DIV_OVF_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule
